airplane_ctrl: RTL and testbench

Game-state and position controller for the VGA airplane sprite. It debounces the player's up, down and start buttons and runs an IDLE/RUN/PAUSE state machine. Once per video frame, during vertical blanking, it updates the 10-bit `airplanex` vertical position consumed by the VGA renderer. Position changes only at frame boundaries, so the sprite never tears mid-frame.

---
 rtl/airplane_ctrl.sv | 147 ++++++++++++++
 tb/tb_airplane_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/airplane_ctrl.sv
// Airplane sprite game controller: button debouncing, IDLE/RUN/PAUSE state machine
// and frame-synchronous vertical position update with clamping and hold-to-recentre.
module airplane_ctrl #(
  parameter int STEP        = 4,
  parameter int Y_MIN       = 11,
  parameter int Y_MAX       = 369,
  parameter int Y_INIT      = 190,
  parameter int DEB_CYCLES  = 500000,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       vsync,
  output logic [9:0] airplanex,
  output logic       frame_tick,
  output logic [1:0] state,
  output logic       running
);

  localparam int          DATA_W    = 10;
  localparam logic [19:0] DEB_LAST  = 20'(DEB_CYCLES - 1);
  localparam logic [5:0]  HOLD_LAST = 6'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // Bit order in the button vectors: [0]=up, [1]=down, [2]=start
  logic [2:0]  sync_p0;
  logic [2:0]  sync_p1;
  logic [2:0]  deb;
  logic [19:0] deb_cnt [3];
  logic        start_d;
  logic        start_evt;
  logic        vsync_prev;

  state_t            state_q, state_n;
  logic [DATA_W-1:0] pos_n;
  logic [5:0]        hold_cnt, hold_n;

  // 11-bit signed arithmetic keeps the subtraction from wrapping before the clamp
  function automatic logic [DATA_W-1:0] sat_up(input logic [DATA_W-1:0] pos);
    logic signed [DATA_W:0] t;
    t = signed'({1'b0, pos}) - signed'(11'(STEP));
    if (t < signed'(11'(Y_MIN))) t = signed'(11'(Y_MIN));
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_down(input logic [DATA_W-1:0] pos);
    logic signed [DATA_W:0] t;
    t = signed'({1'b0, pos}) + signed'(11'(STEP));
    if (t > signed'(11'(Y_MAX))) t = signed'(11'(Y_MAX));
    return t[DATA_W-1:0];
  endfunction

  // Stage p0/p1: synchronisers, then debounce, start edge and frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      deb        <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      start_d    <= 1'b0;
      start_evt  <= 1'b0;
      vsync_prev <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      sync_p0 <= {btn_start, btn_down, btn_up};
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 20'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
      start_d    <= deb[2];
      start_evt  <= deb[2] & ~start_d;
      vsync_prev <= vsync;
      frame_tick <= vsync_prev & ~vsync;
    end
  end

  always_comb begin
    state_n = state_q;
    pos_n   = airplanex;
    hold_n  = hold_cnt;
    case (state_q)
      IDLE: begin
        if (start_evt) state_n = RUN;
      end
      RUN: begin
        if (frame_tick) begin
          if (deb[0] && !deb[1])      pos_n = sat_up(airplanex);
          else if (deb[1] && !deb[0]) pos_n = sat_down(airplanex);
        end
        if (start_evt) state_n = PAUSE;
      end
      PAUSE: begin
        if (start_evt) begin
          state_n = RUN;
        end else if (frame_tick) begin
          if (deb[0] && deb[1]) begin
            if (hold_cnt == HOLD_LAST) begin
              state_n = IDLE;
              pos_n   = DATA_W'(Y_INIT);
            end else begin
              hold_n = hold_cnt + 6'd1;
            end
          end else begin
            hold_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != PAUSE) hold_n = '0;
  end

  // Stage p2: registered state, position and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      airplanex <= DATA_W'(Y_INIT);
      hold_cnt  <= '0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_n;
      airplanex <= pos_n;
      hold_cnt  <= hold_n;
      running   <= (state_n == RUN);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_airplane_ctrl.sv
// Directed scoreboard bench for airplane_ctrl: debounce latency, movement/clamping,
// pause behaviour, recentre, coincident start/frame events and asynchronous reset.
module tb_airplane_ctrl;

  localparam int STEP   = 4;
  localparam int Y_MIN  = 11;
  localparam int Y_MAX  = 369;
  localparam int Y_INIT = 190;
  localparam int DEB    = 4;
  localparam int HOLD   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_start, vsync;
  logic [9:0] airplanex;
  logic       frame_tick;
  logic [1:0] state;
  logic       running;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] sb_q[$];
  int          mdl_pos;
  logic [1:0]  mdl_state;
  int          mdl_hold;
  bit          mdl_up, mdl_down;

  airplane_ctrl #(
    .STEP(STEP), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_INIT(Y_INIT),
    .DEB_CYCLES(DEB), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .vsync(vsync), .airplanex(airplanex),
    .frame_tick(frame_tick), .state(state), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input bit up, input bit down);
    btn_up   = up;
    btn_down = down;
    step(10);
    mdl_up   = up;
    mdl_down = down;
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step(10);
    btn_start = 1'b0;
    step(10);
    case (mdl_state)
      2'b00:   mdl_state = 2'b01;
      2'b01:   mdl_state = 2'b10;
      default: begin mdl_state = 2'b01; mdl_hold = 0; end
    endcase
  endtask

  task automatic frame(input string tag);
    logic [11:0] exp;
    if (mdl_state == 2'b01) begin
      if (mdl_up && !mdl_down)      mdl_pos = (mdl_pos - STEP < Y_MIN) ? Y_MIN : mdl_pos - STEP;
      else if (mdl_down && !mdl_up) mdl_pos = (mdl_pos + STEP > Y_MAX) ? Y_MAX : mdl_pos + STEP;
    end else if (mdl_state == 2'b10) begin
      if (mdl_up && mdl_down) begin
        if (mdl_hold == HOLD - 1) begin
          mdl_state = 2'b00;
          mdl_pos   = Y_INIT;
          mdl_hold  = 0;
        end else begin
          mdl_hold++;
        end
      end else begin
        mdl_hold = 0;
      end
    end
    sb_q.push_back({mdl_state, 10'(mdl_pos)});
    vsync = 1'b0;
    step(1);
    check({tag, "_tick_hi"}, 16'(frame_tick), 16'd1);
    step(1);
    check({tag, "_tick_lo"}, 16'(frame_tick), 16'd0);
    exp = sb_q.pop_front();
    check({tag, "_state_pos"}, 16'({state, airplanex}), 16'(exp));
    vsync = 1'b1;
    step(2);
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0; vsync = 1'b1;
    mdl_pos = Y_INIT; mdl_state = 2'b00; mdl_hold = 0; mdl_up = 0; mdl_down = 0;

    step(1);
    check("rst_pos", 16'(airplanex), 16'(Y_INIT));
    check("rst_state", 16'(state), 16'd0);
    check("rst_running", 16'(running), 16'd0);
    check("rst_tick", 16'(frame_tick), 16'd0);
    step(2);
    reset = 1'b0;
    step(2);

    // Short bounce must be rejected
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(10);
    check("glitch_state", 16'(state), 16'd0);

    // Full press: state changes 2+4+2 edges after the rise
    btn_start = 1'b1;
    step(7);
    check("deb_early", 16'(state), 16'd0);
    step(1);
    check("deb_run", 16'(state), 16'd1);
    check("deb_running", 16'(running), 16'd1);
    step(2);
    btn_start = 1'b0;
    step(10);
    check("release_none", 16'(state), 16'd1);
    mdl_state = 2'b01;

    set_btns(0, 1);
    for (int i = 0; i < 50; i++) frame("down");
    check("clamp_max", 16'(airplanex), 16'(Y_MAX));
    set_btns(1, 0);
    for (int i = 0; i < 100; i++) frame("up");
    check("clamp_min", 16'(airplanex), 16'(Y_MIN));

    press_start();
    check("to_pause", 16'(state), 16'd2);
    set_btns(0, 1);
    for (int i = 0; i < 5; i++) frame("pause_down");
    press_start();
    set_btns(1, 1);
    for (int i = 0; i < 3; i++) frame("run_both");
    check("both_hold", 16'(airplanex), 16'(Y_MIN));

    set_btns(0, 1);
    for (int i = 0; i < 72; i++) frame("to299");
    check("pos299", 16'(airplanex), 16'd299);

    // Interrupted hold must not recentre
    press_start();
    set_btns(1, 1);
    for (int i = 0; i < 2; i++) frame("hold_a");
    set_btns(0, 1);
    frame("hold_break");
    set_btns(1, 1);
    for (int i = 0; i < 2; i++) frame("hold_b");
    check("no_recentre_state", 16'(state), 16'd2);
    check("no_recentre_pos", 16'(airplanex), 16'd299);

    set_btns(0, 1);
    frame("hold_clear");
    set_btns(1, 1);
    for (int i = 0; i < 3; i++) frame("recentre");
    check("recentre_state", 16'(state), 16'd0);
    check("recentre_pos", 16'(airplanex), 16'(Y_INIT));
    check("recentre_running", 16'(running), 16'd0);

    // start_evt coincides with frame_tick in RUN
    set_btns(1, 0);
    press_start();
    btn_start = 1'b1;
    step(6);
    vsync = 1'b0;
    step(1);
    check("coin_tick", 16'(frame_tick), 16'd1);
    check("coin_run", 16'(state), 16'd1);
    step(1);
    check("coin_pos", 16'(airplanex), 16'(Y_INIT - STEP));
    check("coin_pause", 16'(state), 16'd2);
    mdl_pos = Y_INIT - STEP; mdl_state = 2'b10;
    vsync = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(10);

    // Asynchronous reset mid-run while frame_tick is high
    press_start();
    check("pre_reset_state", 16'(state), 16'd1);
    vsync = 1'b0;
    step(1);
    check("pre_reset_tick", 16'(frame_tick), 16'd1);
    #3 reset = 1'b1;
    #1;
    check("async_pos", 16'(airplanex), 16'(Y_INIT));
    check("async_state", 16'(state), 16'd0);
    check("async_running", 16'(running), 16'd0);
    check("async_tick", 16'(frame_tick), 16'd0);
    step(2);
    reset = 1'b0;
    vsync = 1'b1;
    step(3);
    check("post_reset_state", 16'(state), 16'd0);
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
